rom_stream_reader: RTL and testbench

- Upstream/downstream companion to the synchronous enable-gated lookup ROM (1-cycle read latency, DATA_WIDTH x MEM_DEPTH).
- On a start command, walks `count` consecutive ROM addresses from `base_addr`, drives the ROM's address/enable pins and captures the returned words.
- Presents the words as a valid/ready stream with a last flag. An internal 3-entry buffer absorbs downstream backpressure, so no ROM read is ever lost.

---
 rtl/rom_stream_reader_if.sv | 31 +++
 rtl/rom_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_rom_stream_reader.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// ============================================================================
// Module : rom_stream_reader_if
// Brief  : Valid/ready output stream with last flag for rom_stream_reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rom_stream_reader_if #(
   parameter int DATA_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/rom_stream_reader.sv
// ============================================================================
// Module : rom_stream_reader
// Brief  : Walks a burst of ROM addresses and streams the words out through a
//          3-entry buffer. ROM_STREAM_READER_WRAP_EN wraps addresses at MEM_DEPTH.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_stream_reader #(
   parameter int DATA_WIDTH = 12,
   parameter int MEM_DEPTH  = 100,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_address,
   output logic                  rom_enable,
   input  logic [DATA_WIDTH-1:0] rom_data,
   rom_stream_reader_if.master   strm
);

   localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [1:0]            c_BUF_LAST = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   w_addr_inc;
   logic [ADDR_WIDTH:0]     r_remaining;
   logic [ADDR_WIDTH:0]     r_left_out;
   logic                    r_pending;
   logic                    r_done;
   logic [DATA_WIDTH-1:0]   r_buf [0:2];
   logic [1:0]              r_wr_ptr;
   logic [1:0]              r_rd_ptr;
   logic [1:0]              r_buf_count;
   logic [2:0]              w_outstanding;
   logic                    w_valid;
   logic                    w_pop;
   logic                    w_issue;
   logic                    w_accept;
   logic                    w_zero_cmd;
   logic                    w_finish;

`ifdef ROM_STREAM_READER_WRAP_EN
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
   assign w_addr_inc = (r_addr == c_LAST_ADDR) ? '0 : r_addr + c_ADDR_ONE;
`else
   assign w_addr_inc = r_addr + c_ADDR_ONE;
`endif

   // Words already buffered plus the one still coming back from the ROM.
   assign w_outstanding = {1'b0, r_buf_count} + {2'b00, r_pending};
   assign w_valid       = (r_buf_count != 2'd0);
   assign w_pop         = w_valid && strm.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      w_accept    = 1'b0;
      w_zero_cmd  = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (count != '0) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_zero_cmd  = 1'b1;
               end
            end
         end
         S_RUN: begin
            w_issue = (r_remaining != '0) && (w_outstanding < 3'd3);
            if (w_issue && (r_remaining == c_CNT_ONE)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && (r_left_out == c_CNT_ONE)) begin
               w_finish    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_left_out  <= '0;
         r_pending   <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_issue;
         r_done    <= w_zero_cmd | w_finish;
         if (w_accept) begin
            r_addr      <= base_addr;
            r_remaining <= count;
            r_left_out  <= count;
         end else begin
            if (w_issue) begin
               r_addr      <= w_addr_inc;
               r_remaining <= r_remaining - c_CNT_ONE;
            end
            if (w_pop) begin
               r_left_out  <= r_left_out - c_CNT_ONE;
            end
         end
      end
   end

   // Capture is unconditional: issue is throttled so a slot is always free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            r_buf[i] <= '0;
         end
         r_wr_ptr    <= 2'd0;
         r_rd_ptr    <= 2'd0;
         r_buf_count <= 2'd0;
      end else begin
         if (r_pending) begin
            r_buf[r_wr_ptr] <= rom_data;
            r_wr_ptr        <= (r_wr_ptr == c_BUF_LAST) ? 2'd0 : r_wr_ptr + 2'd1;
         end
         if (w_pop) begin
            r_rd_ptr        <= (r_rd_ptr == c_BUF_LAST) ? 2'd0 : r_rd_ptr + 2'd1;
         end
         case ({r_pending, w_pop})
            2'b10:   r_buf_count <= r_buf_count + 2'd1;
            2'b01:   r_buf_count <= r_buf_count - 2'd1;
            default: r_buf_count <= r_buf_count;
         endcase
      end
   end

   assign busy           = (r_state != S_IDLE);
   assign done           = r_done;
   assign rom_address    = r_addr;
   assign rom_enable     = w_issue;
   assign strm.out_valid = w_valid;
   assign strm.out_data  = r_buf[r_rd_ptr];
   assign strm.out_last  = w_valid && (r_left_out == c_CNT_ONE);

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ============================================================================
// Module : tb_rom_stream_reader
// Brief  : Self-checking bench for rom_stream_reader against a ROM model and
//          an address-walk reference built from the burst rules.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_stream_reader;

   logic        clock;
   logic        reset;
   logic        start;
   logic [6:0]  base_addr;
   logic [7:0]  count;
   logic        busy;
   logic        done;
   logic [6:0]  rom_address;
   logic        rom_enable;
   logic [11:0] rom_q;
   logic [11:0] rom_mem [0:127];

   rom_stream_reader_if #(.DATA_WIDTH(12)) s_if ();

   rom_stream_reader #(
      .DATA_WIDTH (12),
      .MEM_DEPTH  (100),
      .ADDR_WIDTH (7)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .rom_address (rom_address),
      .rom_enable  (rom_enable),
      .rom_data    (rom_q),
      .strm        (s_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous enable-gated ROM with ROM[i] = i.
   initial for (int i = 0; i < 128; i++) rom_mem[i] = 12'(i);
   always @(posedge clock) if (rom_enable) rom_q <= rom_mem[rom_address];

   int total = 0;
   int bad   = 0;

   int hs_data [$];
   bit hs_last [$];
   int hs_idx  [$];
   int en_idx  [$];
   int en_addr [$];
   int done_idx[$];
   bit busy_q  [$];
   bit valid_q [$];
   int exp_q   [$];
   int ovf;

   function automatic int next_a(input int a);
`ifdef ROM_STREAM_READER_WRAP_EN
      return (a == 99) ? 0 : (a + 1) % 128;
`else
      return (a + 1) % 128;
`endif
   endfunction

   // Expected address sequence; with ROM[i]=i it is also the expected data.
   task automatic build_exp(input int b, input int c);
      int a = b;
      exp_q.delete();
      for (int i = 0; i < c; i++) begin
         exp_q.push_back(a);
         a = next_a(a);
      end
   endtask

   task automatic issue(input int b, input int c);
      @(negedge clock);
      start     = 1'b1;
      base_addr = 7'(b);
      count     = 8'(c);
   endtask

   // Cycle 0 is the cycle right after the edge that sampled start.
   task automatic run(input int max_cyc, input int stall, input bit rnd,
                      input int mid_idx, input int mid_base, input int mid_cnt);
      int k = 0;
      int extra = -1;
      int issued = 0;
      hs_data.delete(); hs_last.delete(); hs_idx.delete();
      en_idx.delete(); en_addr.delete(); done_idx.delete();
      busy_q.delete(); valid_q.delete();
      ovf = 0;
      while (k < max_cyc && extra != 0) begin
         @(negedge clock);
         start = (k == mid_idx);
         if (k == mid_idx) begin
            base_addr = 7'(mid_base);
            count     = 8'(mid_cnt);
         end
         if (k < stall)  s_if.out_ready = 1'b0;
         else if (rnd)   s_if.out_ready = ($urandom_range(0, 3) != 0);
         else            s_if.out_ready = 1'b1;
         #1;
         busy_q.push_back(busy);
         valid_q.push_back(s_if.out_valid);
         if (done) begin
            done_idx.push_back(k);
            if (extra < 0) extra = 4;
         end
         if (rom_enable) begin
            if (issued - hs_data.size() >= 3) ovf++;
            en_idx.push_back(k);
            en_addr.push_back(int'(rom_address));
            issued++;
         end
         if (s_if.out_valid && s_if.out_ready) begin
            hs_data.push_back(int'(s_if.out_data));
            hs_last.push_back(s_if.out_last);
            hs_idx.push_back(k);
         end
         if (extra > 0) extra--;
         k++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; s_if.out_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      total++;
      if ({busy, done, s_if.out_valid, s_if.out_last, rom_enable} !== 5'b0) begin
         bad++; $display("FAIL reset_status got=%b want=00000",
                         {busy, done, s_if.out_valid, s_if.out_last, rom_enable});
      end
      total++;
      if (rom_address !== 7'd0 || s_if.out_data !== 12'd0) begin
         bad++; $display("FAIL reset_addr_data got=%0d/%0d want=0/0", rom_address, s_if.out_data);
      end
      reset = 1'b0;
      repeat (2) @(negedge clock);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_basic();
      build_exp(5, 4);
      issue(5, 4);
      run(40, 0, 1'b0, -1, 0, 0);
      total++;
      if (hs_data.size() != 4) begin
         bad++; $display("FAIL basic_words got=%0d want=4", hs_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (hs_data[i] != exp_q[i] || hs_last[i] != (i == 3) || hs_idx[i] != 2 + i) begin
               bad++; $display("FAIL basic_word%0d got=%0d last=%b cyc=%0d want=%0d last=%b cyc=%0d",
                               i, hs_data[i], hs_last[i], hs_idx[i], exp_q[i], i == 3, 2 + i);
            end
         end
         total++;
         if (done_idx.size() != 1 || done_idx[0] != hs_idx[3] + 1) begin
            bad++; $display("FAIL basic_done pulses=%0d at=%0d want 1 at %0d",
                            done_idx.size(), done_idx.size() ? done_idx[0] : -1, hs_idx[3] + 1);
         end else begin
            total++;
            if (busy_q[0] !== 1'b1 || busy_q[done_idx[0]] !== 1'b0 || busy_q[done_idx[0] - 1] !== 1'b1) begin
               bad++; $display("FAIL basic_busy first=%b at_done=%b before_done=%b want 1 0 1",
                               busy_q[0], busy_q[done_idx[0]], busy_q[done_idx[0] - 1]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int stalled_reads = 0;
      build_exp(5, 4);
      issue(5, 4);
      run(80, 10, 1'b0, -1, 0, 0);
      foreach (en_idx[i]) if (en_idx[i] < 10) stalled_reads++;
      total++;
      if (stalled_reads != 3 || en_idx.size() != 4) begin
         bad++; $display("FAIL bp_reads stalled=%0d total=%0d want 3 4", stalled_reads, en_idx.size());
      end
      total++;
      if (ovf != 0) begin
         bad++; $display("FAIL bp_credit overissue=%0d want 0", ovf);
      end
      total++;
      if (hs_data.size() != 4 || hs_data[0] != 5 || hs_data[1] != 6 || hs_data[2] != 7 ||
          hs_data[3] != 8 || hs_last[3] != 1'b1 || hs_idx[0] != 10) begin
         bad++; $display("FAIL bp_order n=%0d first=%0d firstcyc=%0d want 4 words 5..8 from cyc 10",
                         hs_data.size(), hs_data.size() ? hs_data[0] : -1, hs_idx.size() ? hs_idx[0] : -1);
      end
      total++;
      if (done_idx.size() != 1) begin
         bad++; $display("FAIL bp_done pulses=%0d want=1", done_idx.size());
      end
   endtask

   task automatic test_wrap();
      build_exp(98, 4);
      issue(98, 4);
      run(40, 0, 1'b0, -1, 0, 0);
      total++;
      if (en_addr.size() != 4 || hs_data.size() != 4) begin
         bad++; $display("FAIL wrap_count reads=%0d words=%0d want 4 4", en_addr.size(), hs_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (en_addr[i] != exp_q[i] || hs_data[i] != exp_q[i]) begin
               bad++; $display("FAIL wrap_%0d addr=%0d data=%0d want %0d", i, en_addr[i], hs_data[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_zero_count();
      int b = 0;
      int v = 0;
      issue(7, 0);
      run(20, 0, 1'b0, -1, 0, 0);
      foreach (busy_q[i]) b += busy_q[i];
      foreach (valid_q[i]) v += valid_q[i];
      total++;
      if (done_idx.size() != 1 || done_idx[0] != 0) begin
         bad++; $display("FAIL zero_done pulses=%0d at=%0d want 1 at 0",
                         done_idx.size(), done_idx.size() ? done_idx[0] : -1);
      end
      total++;
      if (en_idx.size() != 0 || b != 0 || v != 0) begin
         bad++; $display("FAIL zero_quiet reads=%0d busy_cycles=%0d valid_cycles=%0d want 0 0 0",
                         en_idx.size(), b, v);
      end
   endtask

   task automatic test_reset_mid_burst();
      s_if.out_ready = 1'b0;
      issue(20, 10);
      @(negedge clock); start = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #1;
      total++;
      if (s_if.out_valid !== 1'b1 || s_if.out_data !== 12'd20) begin
         bad++; $display("FAIL midrst_pre valid=%b data=%0d want 1 20", s_if.out_valid, s_if.out_data);
      end
      #1 reset = 1'b1;
      #1;
      total++;
      if ({busy, done, s_if.out_valid, s_if.out_last, rom_enable} !== 5'b0 ||
          rom_address !== 7'd0 || s_if.out_data !== 12'd0) begin
         bad++; $display("FAIL midrst_outputs status=%b addr=%0d data=%0d want 0",
                         {busy, done, s_if.out_valid, s_if.out_last, rom_enable}, rom_address, s_if.out_data);
      end
      @(negedge clock); reset = 1'b0;
      build_exp(0, 2);
      issue(0, 2);
      run(40, 0, 1'b0, -1, 0, 0);
      total++;
      if (hs_data.size() != 2 || hs_data[0] != 0 || hs_data[1] != 1 || done_idx.size() != 1) begin
         bad++; $display("FAIL midrst_after words=%0d first=%0d dones=%0d want 2 words 0,1 and 1 done",
                         hs_data.size(), hs_data.size() ? hs_data[0] : -1, done_idx.size());
      end
   endtask

   task automatic test_start_while_busy();
      build_exp(10, 6);
      issue(10, 6);
      run(80, 0, 1'b1, 3, 50, 3);
      total++;
      if (hs_data.size() != 6 || en_addr.size() != 6 || done_idx.size() != 1) begin
         bad++; $display("FAIL busy_start words=%0d reads=%0d dones=%0d want 6 6 1",
                         hs_data.size(), en_addr.size(), done_idx.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (hs_data[i] != exp_q[i] || en_addr[i] != exp_q[i]) begin
               bad++; $display("FAIL busy_start_%0d data=%0d addr=%0d want %0d", i, hs_data[i], en_addr[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         int b = int'($urandom_range(0, 127));
         int c = (it == 0) ? 128 : int'($urandom_range(1, 24));
         build_exp(b, c);
         issue(b, c);
         run(20 + c * 8, 0, 1'b1, -1, 0, 0);
         total++;
         if (hs_data.size() != c || en_addr.size() != c || ovf != 0) begin
            bad++; $display("FAIL rnd%0d_count words=%0d reads=%0d overissue=%0d want %0d %0d 0",
                            it, hs_data.size(), en_addr.size(), ovf, c, c);
            continue;
         end
         for (int i = 0; i < c; i++) begin
            total++;
            if (hs_data[i] != exp_q[i] || en_addr[i] != exp_q[i] || hs_last[i] != (i == c - 1)) begin
               bad++; $display("FAIL rnd%0d_word%0d data=%0d addr=%0d last=%b want %0d last=%b",
                               it, i, hs_data[i], en_addr[i], hs_last[i], exp_q[i], i == c - 1);
            end
         end
         total++;
         if (done_idx.size() != 1 || done_idx[0] != hs_idx[c - 1] + 1) begin
            bad++; $display("FAIL rnd%0d_done pulses=%0d at=%0d want 1 at %0d", it, done_idx.size(),
                            done_idx.size() ? done_idx[0] : -1, hs_idx[c - 1] + 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_count();
      test_reset_mid_burst();
      test_start_while_busy();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
